// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: turns EX/MEM load/store requests into req/ack
// transactions on the data-memory bus and produces the MEM/WB writeback bundle.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              mem_r_ena_i,
    input  logic [ADDR_W-1:0] mem_r_addr_i,
    input  logic              mem_w_ena_i,
    input  logic [ADDR_W-1:0] mem_w_addr_i,
    input  logic [DATA_W-1:0] mem_w_data_i,
    input  logic [31:0]       inst_i,
    input  logic              reg_w_ena_i,
    input  logic [4:0]        reg_w_addr_i,
    input  logic [DATA_W-1:0] reg_w_data_i,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_be_o,
    output logic              hold_o,
    output logic              reg_w_ena_o,
    output logic [4:0]        reg_w_addr_o,
    output logic [DATA_W-1:0] reg_w_data_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              reg_w_ena_q, reg_w_ena_d;
    logic [4:0]        reg_w_addr_q, reg_w_addr_d;
    logic [DATA_W-1:0] reg_w_data_q, reg_w_data_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic              ld_ena_q, ld_ena_d;

    logic              req_any, is_store, legal_f3, aligned, access_ok;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        funct3;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata, ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_inst_bits;

    assign unused_inst_bits = ^{inst_i[31:15], inst_i[11:0]};

    // Stores win when both request lines are raised in the same cycle.
    assign req_any  = mem_r_ena_i | mem_w_ena_i;
    assign is_store = mem_w_ena_i;
    assign acc_addr = is_store ? mem_w_addr_i : mem_r_addr_i;
    assign funct3   = inst_i[14:12];

    always_comb begin
        legal_f3 = 1'b0;
        aligned  = 1'b0;
        if (is_store) legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010};
        else          legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~acc_addr[0];
            2'b10:   aligned = (acc_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end
    assign access_ok = legal_f3 & aligned;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = mem_w_data_i;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << acc_addr[1:0];
                st_wdata = {4{mem_w_data_i[7:0]}};
            end
            2'b01: begin
                st_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_w_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata_i[7:0];
        case (ld_off_q)
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            2'd3:    ld_byte = bus_rdata_i[31:24];
            default: ld_byte = bus_rdata_i[7:0];
        endcase
        ld_half = ld_off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        reg_w_ena_d  = reg_w_ena_q;
        reg_w_addr_d = reg_w_addr_q;
        reg_w_data_d = reg_w_data_q;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        ld_ena_d     = ld_ena_q;
        hold_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_any) begin
                    hold_o       = 1'b1;
                    reg_w_ena_d  = 1'b0;
                    reg_w_addr_d = reg_w_addr_i;
                    if (access_ok) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {acc_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = is_store ? st_wdata : '0;
                        bus_be_d    = is_store ? st_be : 4'b1111;
                        ld_f3_d     = funct3;
                        ld_off_d    = acc_addr[1:0];
                        ld_ena_d    = reg_w_ena_i;
                        state_d     = S_BUSY;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    reg_w_ena_d  = reg_w_ena_i;
                    reg_w_addr_d = reg_w_addr_i;
                    reg_w_data_d = reg_w_data_i;
                end
            end
            S_BUSY: begin
                hold_o = 1'b1;
                if (bus_ack_i || cnt_q == CNT_LAST) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = 4'b0000;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                    reg_w_ena_d = 1'b0;
                    if (!bus_ack_i) begin
                        bus_err_d = 1'b1;
                    end else if (!bus_we_q) begin
                        reg_w_ena_d  = ld_ena_q;
                        reg_w_data_d = ld_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Upstream advances this cycle; the retiring instruction is not re-evaluated.
                reg_w_ena_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) hold_o = 1'b0;
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= 4'b0000;
            reg_w_ena_q  <= 1'b0;
            reg_w_addr_q <= 5'd0;
            reg_w_data_q <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            ld_f3_q      <= 3'b000;
            ld_off_q     <= 2'b00;
            ld_ena_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            reg_w_ena_q  <= reg_w_ena_d;
            reg_w_addr_q <= reg_w_addr_d;
            reg_w_data_q <= reg_w_data_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            ld_ena_q     <= ld_ena_d;
        end
    end

    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_be_o     = bus_be_q;
    assign reg_w_ena_o  = reg_w_ena_q;
    assign reg_w_addr_o = reg_w_addr_q;
    assign reg_w_data_o = reg_w_data_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, ack timeout and
// reset mid-transaction, with expected values computed by hand.
module tb_mem_access_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_ena_i, mem_w_ena_i;
    logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_req_o, bus_we_o, hold_o, reg_w_ena_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, reg_w_data_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  reg_w_addr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_100MHz  (clk),
        .rst         (rst),
        .mem_r_ena_i (mem_r_ena_i),
        .mem_r_addr_i(mem_r_addr_i),
        .mem_w_ena_i (mem_w_ena_i),
        .mem_w_addr_i(mem_w_addr_i),
        .mem_w_data_i(mem_w_data_i),
        .inst_i      (inst_i),
        .reg_w_ena_i (reg_w_ena_i),
        .reg_w_addr_i(reg_w_addr_i),
        .reg_w_data_i(reg_w_data_i),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_be_o    (bus_be_o),
        .hold_o      (hold_o),
        .reg_w_ena_o (reg_w_ena_o),
        .reg_w_addr_o(reg_w_addr_o),
        .reg_w_data_o(reg_w_data_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_r_ena_i  = 1'b0;
        mem_w_ena_i  = 1'b0;
        mem_r_addr_i = '0;
        mem_w_addr_i = '0;
        mem_w_data_i = '0;
        inst_i       = '0;
        reg_w_ena_i  = 1'b0;
        reg_w_addr_i = '0;
        reg_w_data_i = '0;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = '0;
    endtask

    // Caller is at a negedge; returns at the negedge after the DONE cycle.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [31:0] exp_data);
        mem_r_ena_i  = 1'b1;
        mem_r_addr_i = addr;
        inst_i       = {17'h0, f3, 12'h003};
        reg_w_ena_i  = 1'b1;
        reg_w_addr_i = 5'd5;
        reg_w_data_i = 32'h0000_0BAD;
        #1 chk({tag, ".hold_idle"}, 32'(hold_o), 32'd1);
        @(negedge clk);
        chk({tag, ".req"}, 32'(bus_req_o), 32'd1);
        chk({tag, ".we"}, 32'(bus_we_o), 32'd0);
        chk({tag, ".addr"}, bus_addr_o, {addr[31:2], 2'b00});
        chk({tag, ".be"}, 32'(bus_be_o), 32'hF);
        chk({tag, ".hold_busy"}, 32'(hold_o), 32'd1);
        chk({tag, ".wena_busy"}, 32'(reg_w_ena_o), 32'd0);
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        @(negedge clk);
        chk({tag, ".req_done"}, 32'(bus_req_o), 32'd0);
        chk({tag, ".data"}, reg_w_data_o, exp_data);
        chk({tag, ".wena"}, 32'(reg_w_ena_o), 32'd1);
        chk({tag, ".waddr"}, 32'(reg_w_addr_o), 32'd5);
        chk({tag, ".hold_done"}, 32'(hold_o), 32'd0);
        idle_inputs();
        @(negedge clk);
        chk({tag, ".wena_after"}, 32'(reg_w_ena_o), 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] data, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        mem_w_ena_i  = 1'b1;
        mem_w_addr_i = addr;
        mem_w_data_i = data;
        inst_i       = {17'h0, f3, 12'h023};
        reg_w_ena_i  = 1'b1;
        reg_w_addr_i = 5'd9;
        #1 chk({tag, ".hold_idle"}, 32'(hold_o), 32'd1);
        @(negedge clk);
        chk({tag, ".req"}, 32'(bus_req_o), 32'd1);
        chk({tag, ".we"}, 32'(bus_we_o), 32'd1);
        chk({tag, ".addr"}, bus_addr_o, {addr[31:2], 2'b00});
        chk({tag, ".be"}, 32'(bus_be_o), 32'(exp_be));
        chk({tag, ".wdata"}, bus_wdata_o, exp_wdata);
        bus_ack_i = 1'b1;
        @(negedge clk);
        chk({tag, ".req_done"}, 32'(bus_req_o), 32'd0);
        chk({tag, ".wena"}, 32'(reg_w_ena_o), 32'd0);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic run_illegal(input string tag, input logic store, input logic [31:0] addr,
                               input logic [2:0] f3);
        mem_w_ena_i  = store;
        mem_r_ena_i  = ~store;
        mem_w_addr_i = addr;
        mem_r_addr_i = addr;
        inst_i       = {17'h0, f3, 12'h003};
        reg_w_ena_i  = 1'b1;
        #1 chk({tag, ".hold_req"}, 32'(hold_o), 32'd1);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(misalign_o), 32'd1);
        chk({tag, ".req"}, 32'(bus_req_o), 32'd0);
        chk({tag, ".wena"}, 32'(reg_w_ena_o), 32'd0);
        idle_inputs();
        #1 chk({tag, ".hold_next"}, 32'(hold_o), 32'd0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(misalign_o), 32'd0);
        chk({tag, ".req_next"}, 32'(bus_req_o), 32'd0);
    endtask

    initial begin : main
        int busy_cycles;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.req", 32'(bus_req_o), 32'd0);
        chk("reset.hold", 32'(hold_o), 32'd0);
        chk("reset.wena", 32'(reg_w_ena_o), 32'd0);
        chk("reset.wdata", reg_w_data_o, 32'd0);
        chk("reset.misalign", 32'(misalign_o), 32'd0);
        chk("reset.err", 32'(bus_err_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_load("lw",  32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_load("lb",  32'h0000_0103, 3'b000, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lbu", 32'h0000_0103, 3'b100, 32'h80FF_FFFF, 32'h0000_0080);
        run_load("lhu", 32'h0000_0102, 3'b101, 32'h80FF_FFFF, 32'h0000_80FF);
        run_load("lh",  32'h0000_0102, 3'b001, 32'h80FF_FFFF, 32'hFFFF_80FF);
        run_load("lb1", 32'h0000_0011, 3'b000, 32'h1122_3344, 32'h0000_0033);

        run_store("sh", 32'h0000_0206, 3'b001, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        run_store("sb", 32'h0000_0101, 3'b000, 32'hAAAA_AA77, 4'b0010, 32'h7777_7777);
        run_store("sw", 32'h0000_0208, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        run_illegal("mis_lw", 1'b0, 32'h0000_0101, 3'b010);
        run_illegal("mis_sh", 1'b1, 32'h0000_0203, 3'b001);
        run_illegal("bad_f3", 1'b1, 32'h0000_0200, 3'b100);

        // Ack withheld: request should stay up for exactly TIMEOUT cycles.
        mem_w_ena_i  = 1'b1;
        mem_w_addr_i = 32'h0000_0300;
        mem_w_data_i = 32'h0F0F_0F0F;
        inst_i       = {17'h0, 3'b010, 12'h023};
        @(negedge clk);
        busy_cycles = 0;
        while (bus_req_o && busy_cycles < TIMEOUT + 20) begin
            busy_cycles++;
            @(negedge clk);
        end
        chk("timeout.busy_cycles", 32'(busy_cycles), 32'(TIMEOUT));
        chk("timeout.err", 32'(bus_err_o), 32'd1);
        chk("timeout.req", 32'(bus_req_o), 32'd0);
        chk("timeout.wena", 32'(reg_w_ena_o), 32'd0);
        chk("timeout.hold", 32'(hold_o), 32'd0);
        idle_inputs();
        @(negedge clk);
        chk("timeout.err_end", 32'(bus_err_o), 32'd0);
        chk("timeout.hold_idle", 32'(hold_o), 32'd0);

        // Reset in BUSY, then a late ack must be ignored.
        mem_r_ena_i  = 1'b1;
        mem_r_addr_i = 32'h0000_0400;
        inst_i       = {17'h0, 3'b010, 12'h003};
        reg_w_ena_i  = 1'b1;
        reg_w_addr_i = 5'd3;
        @(negedge clk);
        chk("rstbusy.req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        idle_inputs();
        #1 chk("rstbusy.hold_in_rst", 32'(hold_o), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        chk("rstbusy.req_drop", 32'(bus_req_o), 32'd0);
        chk("rstbusy.hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        chk("lateack.wena", 32'(reg_w_ena_o), 32'd0);
        chk("lateack.wdata", reg_w_data_o, 32'd0);
        chk("lateack.req", 32'(bus_req_o), 32'd0);
        idle_inputs();
        reg_w_ena_i  = 1'b1;
        reg_w_addr_i = 5'd7;
        reg_w_data_i = 32'h0000_0055;
        #1 chk("alu.hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        chk("alu.wdata", reg_w_data_o, 32'h0000_0055);
        chk("alu.wena", 32'(reg_w_ena_o), 32'd1);
        chk("alu.waddr", 32'(reg_w_addr_o), 32'd7);
        idle_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
